// File: rtl/scalar_writeback_arbiter.sv
// scalar_writeback_arbiter
// Merges single-cycle ALU results and variable-latency load results onto the
// scalar register file's single write port. ALU writes always win. Loads are
// buffered in a FIFO and drained when the ALU is idle. A younger ALU write
// squashes queued loads to the same register (WAW).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   aluValid/Reg/Data   ALU result (never stalled)
//   memValid/Reg/Data   load result offer
//   memReady            load accepted this cycle (combinational)
//   regWrEn/regToWrite/dataIn  registered register-file write port
//   pendingCount        FIFO occupancy, squashed entries included
module scalar_writeback_arbiter #(
  parameter int unsigned registerSize  = 8,
  parameter int unsigned selectionBits = 2,
  parameter int unsigned fifoDepth     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         aluValid,
  input  logic [selectionBits-1:0]     aluReg,
  input  logic [registerSize-1:0]      aluData,
  input  logic                         memValid,
  input  logic [selectionBits-1:0]     memReg,
  input  logic [registerSize-1:0]      memData,
  output logic                         memReady,
  output logic                         regWrEn,
  output logic [selectionBits-1:0]     regToWrite,
  output logic [registerSize-1:0]      dataIn,
  output logic [$clog2(fifoDepth):0]   pendingCount
);

  localparam int unsigned PTR_W = $clog2(fifoDepth);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                     valid;
    logic [selectionBits-1:0] dst;
    logic [registerSize-1:0]  data;
  } entry_t;

  entry_t             fifo_q [fifoDepth];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic               push_c;
  logic               pop_c;
  entry_t             head_c;

  // Accept/pop decisions; full FIFO refuses a load even if it pops this cycle
  always_comb begin
    memReady = !reset && (pendingCount < CNT_W'(fifoDepth));
    push_c   = memValid && memReady;
    pop_c    = !aluValid && (pendingCount != '0);
    head_c   = fifo_q[rd_ptr_q];
  end

  // FIFO storage, pointers, occupancy and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(fifoDepth); i++) begin
        fifo_q[PTR_W'(i)] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      pendingCount <= '0;
      regWrEn      <= 1'b0;
      regToWrite   <= '0;
      dataIn       <= '0;
    end else begin
      // WAW squash of older queued loads; the push below overrides its own slot
      if (aluValid) begin
        for (int i = 0; i < int'(fifoDepth); i++) begin
          if (fifo_q[PTR_W'(i)].dst == aluReg) begin
            fifo_q[PTR_W'(i)].valid <= 1'b0;
          end
        end
      end

      if (push_c) begin
        fifo_q[wr_ptr_q] <= '{valid: 1'b1, dst: memReg, data: memData};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end

      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
        2'b10:   pendingCount <= pendingCount + CNT_W'(1);
        2'b01:   pendingCount <= pendingCount - CNT_W'(1);
        default: pendingCount <= pendingCount;
      endcase

      // Port selection: ALU first, then FIFO head; idle holds reg/data
      if (aluValid) begin
        regWrEn    <= 1'b1;
        regToWrite <= aluReg;
        dataIn     <= aluData;
      end else if (pop_c) begin
        regWrEn    <= head_c.valid;
        regToWrite <= head_c.dst;
        dataIn     <= head_c.data;
      end else begin
        regWrEn    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/scalar_writeback_arbiter.md
Name: scalar_writeback_arbiter

Overview:
Writeback stage directly upstream of scalarRegisterFile. Merges two result sources, the single-cycle scalar ALU and the variable-latency memory-load path, onto the register file's single write port (regWrEn/regToWrite/dataIn). ALU results are never stalled. Load results are buffered in a small FIFO and drained when the port is free, with backpressure to the load unit.

Parameters:
registerSize, 8, data width of a scalar register.
selectionBits, 2, register index width (registerQuantity = 2**selectionBits).
fifoDepth, 4, load-result buffer entries (power of 2, >= 2).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
aluValid  input  1  ALU result present this cycle.
aluReg  input  selectionBits  ALU destination register.
aluData  input  registerSize  ALU result.
memValid  input  1  load result offered this cycle.
memReg  input  selectionBits  load destination register.
memData  input  registerSize  load data.
memReady  output  1  arbiter accepts a load this cycle.
regWrEn  output  1  to register file write enable.
regToWrite  output  selectionBits  to register file write select.
dataIn  output  registerSize  to register file write data.
pendingCount  output  clog2(fifoDepth)+1  FIFO occupancy, including squashed entries.

Behaviour:
- Reset is synchronous, active-high, and sampled on the rising edge of clk. On reset: regWrEn=0, regToWrite=0, dataIn=0, pendingCount=0, FIFO emptied, all valid bits cleared.
- memReady is combinational: memReady = !reset && (pendingCount < fifoDepth). It is low when full even if a pop happens in the same cycle.
- Load accept: memValid && memReady at a rising edge pushes {memReg, memData, valid=1} to the FIFO tail. There is no direct bypass; every load goes through the FIFO.
- Write port selection each cycle. Outputs are registered, so the write appears on the ports 1 cycle after selection and the register file commits it on the following edge.
  - aluValid=1: output {1, aluReg, aluData}. The FIFO is not popped.
  - else if FIFO non-empty: pop the head. Output {head.valid, head.reg, head.data}. A squashed head pops with regWrEn=0 and consumes the slot.
  - else: regWrEn=0. regToWrite and dataIn hold their previous values.
- WAW squash: when aluValid=1, every entry already in the FIFO with reg == aluReg has its valid bit cleared in the same edge. A load pushed in that same edge is not squashed and writes later, after the ALU value.
- Simultaneous push and pop: occupancy is unchanged. A push into an empty FIFO cannot be popped in the same cycle, so minimum load latency is accept, then +1 cycle pop/select, then +1 cycle registered output.
- Pointers wrap modulo fifoDepth. pendingCount never exceeds fifoDepth and never underflows.
- Reset during operation discards all queued loads without writing them. A write already on the outputs is cancelled: regWrEn=0 after the reset edge.
- ALU starvation of the FIFO is permitted. Loads wait indefinitely while aluValid is continuously high; memReady goes low once the FIFO is full.

Test Plan:
1. Reset, then aluValid=1, aluReg=1, aluData=8'hFE for 1 cycle -> next cycle regWrEn=1, regToWrite=1, dataIn=8'hFE. The following cycle regWrEn=0. Register file then reads reg1Out=8'hFE via rSel1=1.
2. Idle ALU; memValid=1, memReg=3, memData=8'hFA for 1 cycle -> pendingCount=1 after the edge. regWrEn=1, regToWrite=3, dataIn=8'hFA two cycles after accept. pendingCount returns to 0.
3. Hold aluValid=1 (aluReg=0) and issue 5 loads back to back -> memReady drops after the 4th accept and pendingCount=4. The 5th load is held by the source. Drop aluValid -> loads drain in FIFO order, one per cycle, and memReady rises after the first pop.
4. Queue a load {reg2, 8'h11}, then in the next cycle aluValid=1, aluReg=2, aluData=8'h22 -> ALU write of 8'h22 to reg 2. The queued entry later pops with regWrEn=0. Final reg 2 value is 8'h22.
5. Same cycle: aluValid=1 {reg1, 8'hAA} and memValid=1 {reg1, 8'hBB} accepted -> ALU write of 8'hAA first, load write of 8'hBB on a later cycle. Final reg 1 value is 8'hBB.
6. Queue 3 loads, assert reset for 1 cycle -> pendingCount=0 and regWrEn=0 after the reset edge. No queued write ever reaches the register file.
